// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle control FSM for the NPC core.
//
// Walks each instruction through fetch, decode, execute, optional memory
// access and writeback. It owns the instruction register and the retired
// instruction counter. A bus watchdog bounds every wait for a memory
// response.
//
// Ports
//   clk, rst              core clock; asynchronous active-high reset
//   ifu_req_valid/ready   fetch request handshake to instruction memory
//   ifu_rsp_valid/inst    fetched instruction return
//   inst_o                instruction register (to imm gen / decoder)
//   lsu_req_valid/we/ready data access request (we=1 store, 0 load)
//   lsu_rsp_valid         load data / store acknowledge
//   rf_we, pc_we          writeback strobes (Moore, asserted in WB)
//   halt_o                sticky halt; ebreak_o/illegal_o/timeout_o give the cause
//   instret_o             retired instruction count
//   state_o               current FSM state, for debug
module exec_sequencer #(
  parameter logic [31:0] RESET_INST = 32'h00000013,
  parameter int          TIMEOUT    = 255,
  parameter int          CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  input  logic        ifu_rsp_valid,
  input  logic [31:0] ifu_rsp_inst,
  output logic [31:0] inst_o,
  output logic        lsu_req_valid,
  output logic        lsu_req_we,
  input  logic        lsu_req_ready,
  input  logic        lsu_rsp_valid,
  output logic        rf_we,
  output logic        pc_we,
  output logic        halt_o,
  output logic        ebreak_o,
  output logic        illegal_o,
  output logic        timeout_o,
  output logic [31:0] instret_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    FETCH_REQ  = 3'd0,
    FETCH_WAIT = 3'd1,
    DECODE     = 3'd2,
    EXEC       = 3'd3,
    MEM_REQ    = 3'd4,
    MEM_WAIT   = 3'd5,
    WB         = 3'd6,
    HALT       = 3'd7
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [31:0] EBREAK   = 32'h00100073;

  function automatic logic opcode_legal(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011:
        opcode_legal = 1'b1;
      default: opcode_legal = 1'b0;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [31:0]      inst_q, inst_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic [31:0]      instret_q, instret_d;
  logic             ebreak_q, ebreak_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;

  logic [6:0]       opcode;
  logic [CNT_W-1:0] wdog_inc;
  logic             wdog_expire;

  assign opcode   = inst_q[6:0];
  assign wdog_inc = wdog_q + 1'b1;
  // The wait cycle that would bring the count up to TIMEOUT is the last one
  // allowed, so the halt lands exactly TIMEOUT cycles after entering the wait.
  assign wdog_expire = (TIMEOUT != 0) && (wdog_inc == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH_REQ;
      inst_q    <= RESET_INST;
      wdog_q    <= '0;
      instret_q <= '0;
      ebreak_q  <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      wdog_q    <= wdog_d;
      instret_q <= instret_d;
      ebreak_q  <= ebreak_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    wdog_d    = wdog_q;
    instret_d = instret_q;
    ebreak_d  = ebreak_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;

    case (state_q)
      FETCH_REQ: begin
        // A stray response left over from an abandoned fetch is ignored here.
        if (ifu_req_ready) begin
          state_d = FETCH_WAIT;
          wdog_d  = '0;
        end
      end
      FETCH_WAIT: begin
        if (ifu_rsp_valid) begin
          inst_d  = ifu_rsp_inst;
          state_d = DECODE;
        end else if (wdog_expire) begin
          state_d   = HALT;
          timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      DECODE: begin
        if (inst_q == EBREAK) begin
          state_d  = HALT;
          ebreak_d = 1'b1;
        end else if (!opcode_legal(opcode)) begin
          state_d   = HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (opcode == OP_LOAD || opcode == OP_STORE) state_d = MEM_REQ;
        else                                         state_d = WB;
      end
      MEM_REQ: begin
        if (lsu_req_ready) begin
          state_d = MEM_WAIT;
          wdog_d  = '0;
        end
      end
      MEM_WAIT: begin
        if (lsu_rsp_valid) begin
          state_d = WB;
        end else if (wdog_expire) begin
          state_d   = HALT;
          timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      WB: begin
        instret_d = instret_q + 32'd1;
        state_d   = FETCH_REQ;
      end
      HALT: begin
        state_d = HALT;
      end
      default: state_d = HALT;
    endcase
  end

  // Moore outputs: pure functions of state (and of the held instruction).
  assign ifu_req_valid = (state_q == FETCH_REQ);
  assign lsu_req_valid = (state_q == MEM_REQ);
  assign lsu_req_we    = (state_q == MEM_REQ) && (opcode == OP_STORE);
  assign pc_we         = (state_q == WB);
  assign rf_we         = (state_q == WB) && (opcode != OP_STORE) && (opcode != OP_BRANCH);
  assign halt_o        = (state_q == HALT);
  assign state_o       = state_q;
  assign inst_o        = inst_q;
  assign instret_o     = instret_q;
  assign ebreak_o      = ebreak_q;
  assign illegal_o     = illegal_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_exec_sequencer.sv
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifu_req_valid;
  logic        ifu_req_ready = 1'b0;
  logic        ifu_rsp_valid = 1'b0;
  logic [31:0] ifu_rsp_inst  = 32'h0;
  logic [31:0] inst_o;
  logic        lsu_req_valid;
  logic        lsu_req_we;
  logic        lsu_req_ready = 1'b0;
  logic        lsu_rsp_valid = 1'b0;
  logic        rf_we;
  logic        pc_we;
  logic        halt_o;
  logic        ebreak_o;
  logic        illegal_o;
  logic        timeout_o;
  logic [31:0] instret_o;
  logic [2:0]  state_o;

  int checks   = 0;
  int failures = 0;

  exec_sequencer #(.RESET_INST(32'h00000013), .TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_inst(ifu_rsp_inst),
    .inst_o(inst_o),
    .lsu_req_valid(lsu_req_valid), .lsu_req_we(lsu_req_we),
    .lsu_req_ready(lsu_req_ready), .lsu_rsp_valid(lsu_rsp_valid),
    .rf_we(rf_we), .pc_we(pc_we), .halt_o(halt_o),
    .ebreak_o(ebreak_o), .illegal_o(illegal_o), .timeout_o(timeout_o),
    .instret_o(instret_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
  endtask

  // From FETCH_REQ: one-cycle ready, response the next cycle; ends in DECODE.
  task automatic fetch(input logic [31:0] inst);
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b1;
    ifu_rsp_inst  = inst;
    step();
    ifu_rsp_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    #12;
    check("rst_state",   32'(state_o), 32'd0);
    check("rst_inst",    inst_o, 32'h00000013);
    check("rst_instret", instret_o, 32'd0);
    check("rst_causes",  {29'd0, ebreak_o, illegal_o, timeout_o}, 32'd0);
    check("rst_ifu_vld", 32'(ifu_req_valid), 32'd1);
    check("rst_halt",    32'(halt_o), 32'd0);
    rst = 1'b0;
    step();

    // ALU op: addi x1,x0,5 -> 0,1,2,3,6,0
    ifu_req_ready = 1'b1;
    step();
    check("alu_fw", 32'(state_o), 32'd1);
    check("alu_fw_ifuvld", 32'(ifu_req_valid), 32'd0);
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b1;
    ifu_rsp_inst  = 32'h00500093;
    step();
    ifu_rsp_valid = 1'b0;
    check("alu_dec", 32'(state_o), 32'd2);
    check("alu_inst", inst_o, 32'h00500093);
    check("alu_dec_strobes", {30'd0, rf_we, pc_we}, 32'd0);
    step();
    check("alu_exec", 32'(state_o), 32'd3);
    check("alu_exec_strobes", {30'd0, rf_we, pc_we}, 32'd0);
    step();
    check("alu_wb", 32'(state_o), 32'd6);
    check("alu_wb_strobes", {30'd0, rf_we, pc_we}, 32'd3);
    step();
    check("alu_back", 32'(state_o), 32'd0);
    check("alu_instret", instret_o, 32'd1);
    check("alu_back_strobes", {30'd0, rf_we, pc_we}, 32'd0);

    // Load: lw, LSU ready after 2 cycles
    fetch(32'h0000A103);
    step();
    check("lw_exec", 32'(state_o), 32'd3);
    step();
    check("lw_mreq1", {29'd0, state_o}, 32'd4);
    check("lw_vld1", {30'd0, lsu_req_valid, lsu_req_we}, 32'd2);
    step();
    check("lw_vld2", {30'd0, lsu_req_valid, lsu_req_we}, 32'd2);
    step();
    check("lw_vld3", {30'd0, lsu_req_valid, lsu_req_we}, 32'd2);
    lsu_req_ready = 1'b1;
    step();
    lsu_req_ready = 1'b0;
    check("lw_mwait", 32'(state_o), 32'd5);
    check("lw_mwait_vld", 32'(lsu_req_valid), 32'd0);
    lsu_rsp_valid = 1'b1;
    step();
    lsu_rsp_valid = 1'b0;
    check("lw_wb", 32'(state_o), 32'd6);
    check("lw_wb_strobes", {30'd0, rf_we, pc_we}, 32'd3);
    step();
    check("lw_instret", instret_o, 32'd2);

    // Store: sw
    fetch(32'h0020A023);
    step();
    step();
    check("sw_mreq", {29'd0, state_o}, 32'd4);
    check("sw_we", {30'd0, lsu_req_valid, lsu_req_we}, 32'd3);
    lsu_req_ready = 1'b1;
    step();
    lsu_req_ready = 1'b0;
    lsu_rsp_valid = 1'b1;
    step();
    lsu_rsp_valid = 1'b0;
    check("sw_wb", 32'(state_o), 32'd6);
    check("sw_wb_strobes", {30'd0, rf_we, pc_we}, 32'd1);
    step();
    check("sw_instret", instret_o, 32'd3);

    // Branch: beq skips memory states
    fetch(32'h00208463);
    step();
    check("beq_exec", 32'(state_o), 32'd3);
    step();
    check("beq_wb", 32'(state_o), 32'd6);
    check("beq_wb_strobes", {30'd0, rf_we, pc_we}, 32'd1);
    step();
    check("beq_instret", instret_o, 32'd4);

    // Ebreak
    fetch(32'h00100073);
    step();
    check("ebk_state", 32'(state_o), 32'd7);
    check("ebk_halt", 32'(halt_o), 32'd1);
    check("ebk_causes", {29'd0, ebreak_o, illegal_o, timeout_o}, 32'd4);
    check("ebk_instret", instret_o, 32'd4);
    ifu_req_ready = 1'b1;
    ifu_rsp_valid = 1'b1;
    lsu_req_ready = 1'b1;
    lsu_rsp_valid = 1'b1;
    step();
    step();
    check("ebk_absorb", 32'(state_o), 32'd7);
    check("ebk_outs", {27'd0, ifu_req_valid, lsu_req_valid, lsu_req_we, rf_we, pc_we}, 32'd0);
    check("ebk_inst_frozen", inst_o, 32'h00100073);
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    lsu_req_ready = 1'b0;
    lsu_rsp_valid = 1'b0;

    // Async reset is immediate
    rst = 1'b1;
    #2;
    check("arst_state", 32'(state_o), 32'd0);
    check("arst_causes", {29'd0, ebreak_o, illegal_o, timeout_o}, 32'd0);
    check("arst_instret", instret_o, 32'd0);
    rst = 1'b0;
    step();

    // Illegal opcode
    fetch(32'hFFFFFFFF);
    step();
    check("ill_state", 32'(state_o), 32'd7);
    check("ill_causes", {29'd0, ebreak_o, illegal_o, timeout_o}, 32'd2);
    do_reset();

    // Watchdog: no response, halt exactly 4 cycles after entering FETCH_WAIT
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    check("wd_fw", 32'(state_o), 32'd1);
    step();
    step();
    step();
    check("wd_still_wait", 32'(state_o), 32'd1);
    step();
    check("wd_halt", 32'(state_o), 32'd7);
    check("wd_causes", {29'd0, ebreak_o, illegal_o, timeout_o}, 32'd1);
    do_reset();

    // Watchdog: response on wait cycle 3 decodes normally
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    step();
    step();
    step();
    ifu_rsp_valid = 1'b1;
    ifu_rsp_inst  = 32'h00500093;
    step();
    ifu_rsp_valid = 1'b0;
    check("wd_late_dec", 32'(state_o), 32'd2);
    check("wd_late_to", 32'(timeout_o), 32'd0);
    step();
    step();
    step();
    check("wd_late_retire", {29'd0, state_o}, 32'd0);
    check("wd_late_instret", instret_o, 32'd1);

    // Async reset in MEM_WAIT, then stray responses
    fetch(32'h0000A103);
    step();
    step();
    lsu_req_ready = 1'b1;
    step();
    lsu_req_ready = 1'b0;
    check("mr_mwait", 32'(state_o), 32'd5);
    rst = 1'b1;
    #1;
    check("mr_state", 32'(state_o), 32'd0);
    check("mr_inst", inst_o, 32'h00000013);
    check("mr_instret", instret_o, 32'd0);
    #1;
    rst = 1'b0;
    lsu_rsp_valid = 1'b1;
    ifu_rsp_valid = 1'b1;
    ifu_rsp_inst  = 32'h00500093;
    step();
    step();
    lsu_rsp_valid = 1'b0;
    ifu_rsp_valid = 1'b0;
    check("mr_stray_state", 32'(state_o), 32'd0);
    check("mr_stray_inst", inst_o, 32'h00000013);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
